aes_enc_scheduler: RTL and testbench
====================================

Name: aes_enc_scheduler

Overview:
- Front-end controller for the pipelined AES-256 encryption core; the core cannot stall once a block is issued.
- Accepts plaintext blocks over a valid/ready interface and issues them into the core.
- Issue is gated by S-box readiness, a loaded key and output-buffer credits, so core results are never dropped.
- Sequences key changes by draining the pipeline first; buffers ciphertext in a response FIFO toward the consumer.

Parameters:
- PIPE_LAT, 106: cycles from core_in_ready to matching core_out_ready; informational, used only by bench/assertions.
- FIFO_DEPTH, 8: response FIFO entries; also the total credit count (max in-flight + buffered).
- CNT_W, 8: width of inflight counter; must hold PIPE_LAT + FIFO_DEPTH.

Ports:
- clk  in  1  clock
- reset  in  1  reset; asynchronous assert, active-low (0 = reset)
- req_valid  in  1  plaintext block offered
- req_ready  out  1  block accepted this cycle when req_valid & req_ready
- req_data  in  128  plaintext, bit 0 = MSB
- key_load  in  1  one-cycle pulse: new key on key_in
- key_in  in  256  AES-256 cipher key
- key_busy  out  1  key change pending or in progress
- core_in_data  out  128  block to core
- core_in_ready  out  1  one-cycle issue strobe to core
- core_key  out  256  key held stable for core key expansion
- core_sbox_ready  in  1  core S-boxes initialised
- core_out_data  in  128  ciphertext from core
- core_out_ready  in  1  ciphertext valid strobe
- rsp_valid  out  1  ciphertext available
- rsp_ready  in  1  consumer takes rsp_data
- rsp_data  out  128  ciphertext
- inflight  out  CNT_W  blocks issued, not yet returned
- err_sticky  out  1  unexpected core_out_ready or FIFO overflow; cleared only by reset

Behaviour:
- Reset: all outputs 0; core_key = 0; FIFO empty; state WAIT_SBOX.
- States:
  - WAIT_SBOX: go to NO_KEY when core_sbox_ready = 1.
  - NO_KEY: on key_load, latch key_in into core_key; go to RUN next cycle.
  - RUN: issuing allowed. key_load -> DRAIN; key_in captured into a shadow register.
  - DRAIN: no issue. When inflight == 0, copy shadow to core_key; go to RUN next cycle.
- key_load in any state other than NO_KEY/RUN: ignored, sets err_sticky.
- key_busy = 1 in NO_KEY and DRAIN.
- Credit rule: credit_ok = (inflight + fifo_count) < FIFO_DEPTH, using the registered values of that cycle.
- req_ready = (state == RUN) & credit_ok & ~key_load. Combinational; key_load has priority over a same-cycle request.
- Issue: on accept, core_in_data <= req_data and core_in_ready <= 1 on the next edge. Pulse lasts exactly one cycle. Back-to-back accepts yield consecutive pulses.
- inflight: +1 on core_in_ready, -1 on core_out_ready; both in the same cycle = unchanged.
- core_out_ready with inflight == 0: set err_sticky, data still written if FIFO not full.
- FIFO write on core_out_ready. Write when full: data dropped, err_sticky set. Unreachable under the credit rule.
- FIFO simultaneous read and write when full: both succeed.
- Response FIFO is first-word-fall-through. rsp_valid = ~empty; pop on rsp_valid & rsp_ready.
- Ordering: strict FIFO; ciphertext order equals plaintext acceptance order.
- Latency: req accept at cycle T -> core_in_ready at T+1 -> core_out_ready at T+1+PIPE_LAT -> rsp_valid at T+2+PIPE_LAT (FIFO previously empty).
- core_sbox_ready dropping in RUN: no new issue; state returns to WAIT_SBOX once inflight == 0. core_key is retained.
- Reset mid-operation: state, counters and FIFO cleared immediately. In-flight core results arriving after reset release set err_sticky.

Decomposition:
- Shared package aes_pkg: BLOCK_W = 128, KEY_W = 256, state encoding (WAIT_SBOX, NO_KEY, RUN, DRAIN).
- One sub-module aes_rsp_fifo: parameterised width/depth, first-word-fall-through, exposes count/full/empty.

Test Plan:
- Reset, core_sbox_ready = 0 -> req_ready stays 0; raise sbox, load key 000102…1f, send 00112233445566778899aabbccddeeff -> rsp_data = 8ea2b7ca516745bfeafc49904b496089, rsp_valid at accept + PIPE_LAT + 2.
- 20 back-to-back requests, rsp_ready = 1 -> 20 in-order responses, inflight peaks ≤ 8, err_sticky = 0.
- rsp_ready = 0 throughout -> exactly 8 accepted, req_ready = 0 thereafter. Release rsp_ready -> flow resumes, no loss.
- key_load while 3 blocks in flight -> req_ready = 0 until inflight = 0. First 3 results use old key, next block uses new key, key_busy deasserts.
- Spurious core_out_ready with inflight = 0 -> err_sticky = 1, persists until reset.
- Assert reset with 5 in flight -> all outputs 0 at once, FIFO empty, state WAIT_SBOX.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared widths and scheduler state encoding for the AES-256 front end
package aes_pkg;

  localparam int BLOCK_W = 128;
  localparam int KEY_W   = 256;

  typedef enum logic [1:0] {
    WAIT_SBOX = 2'd0,
    NO_KEY    = 2'd1,
    RUN       = 2'd2,
    DRAIN     = 2'd3
  } sched_state_t;

endpackage

// File: rtl/aes_rsp_fifo.sv
// rtl/aes_rsp_fifo.sv - first-word-fall-through response FIFO with occupancy count
module aes_rsp_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_rd    = rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign do_wr    = wr_en & (~full | do_rd);
  assign overflow = wr_en & ~do_wr;
  assign rd_data  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= next_ptr(wr_ptr);
      if (do_rd) rd_ptr <= next_ptr(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/aes_enc_scheduler.sv
// rtl/aes_enc_scheduler.sv - issue, credit and key-change sequencing in front of the AES-256 pipeline
module aes_enc_scheduler
  import aes_pkg::*;
#(
  parameter int PIPE_LAT   = 106,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [BLOCK_W-1:0] req_data,
  input  logic               key_load,
  input  logic [KEY_W-1:0]   key_in,
  output logic               key_busy,
  output logic [BLOCK_W-1:0] core_in_data,
  output logic               core_in_ready,
  output logic [KEY_W-1:0]   core_key,
  input  logic               core_sbox_ready,
  input  logic [BLOCK_W-1:0] core_out_data,
  input  logic               core_out_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [BLOCK_W-1:0] rsp_data,
  output logic [CNT_W-1:0]   inflight,
  output logic               err_sticky
);

  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  if (CNT_W < $clog2(PIPE_LAT + FIFO_DEPTH + 1)) begin : g_cnt_w_check
    $error("CNT_W cannot hold PIPE_LAT + FIFO_DEPTH");
  end

  sched_state_t      state;
  sched_state_t      state_next;
  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_overflow;
  logic [CNT_W:0]    credit_sum;
  logic              credit_ok;
  logic              inflight_zero;
  logic              accept;
  logic              ret_ok;
  logic              load_key;
  logic              capture_shadow;
  logic              swap_key;
  logic              key_err;
  logic [KEY_W-1:0]  shadow_key;

  // inflight counts a block from its accept edge, so credit covers the issue pulse too.
  assign credit_sum    = {1'b0, inflight} + (CNT_W + 1)'(fifo_count);
  assign credit_ok     = credit_sum < (CNT_W + 1)'(FIFO_DEPTH);
  assign inflight_zero = (inflight == '0);
  assign accept        = req_valid & req_ready;
  assign ret_ok        = core_out_ready & ~inflight_zero;
  assign rsp_valid     = ~fifo_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= WAIT_SBOX;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      WAIT_SBOX: if (core_sbox_ready) state_next = NO_KEY;
      NO_KEY:    if (key_load) state_next = RUN;
      RUN: begin
        if (key_load)                              state_next = DRAIN;
        else if (!core_sbox_ready && inflight_zero) state_next = WAIT_SBOX;
      end
      DRAIN:     if (inflight_zero) state_next = RUN;
      default:   state_next = WAIT_SBOX;
    endcase
  end

  always_comb begin
    req_ready      = 1'b0;
    key_busy       = 1'b0;
    load_key       = 1'b0;
    capture_shadow = 1'b0;
    swap_key       = 1'b0;
    key_err        = 1'b0;
    case (state)
      WAIT_SBOX: key_err = key_load;
      NO_KEY: begin
        key_busy = 1'b1;
        load_key = key_load;
      end
      RUN: begin
        req_ready      = credit_ok & core_sbox_ready & ~key_load;
        capture_shadow = key_load;
      end
      DRAIN: begin
        key_busy = 1'b1;
        swap_key = inflight_zero;
        key_err  = key_load;
      end
      default: key_err = key_load;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_key      <= '0;
      shadow_key    <= '0;
      core_in_data  <= '0;
      core_in_ready <= 1'b0;
      inflight      <= '0;
      err_sticky    <= 1'b0;
    end else begin
      if (load_key)       core_key   <= key_in;
      if (capture_shadow) shadow_key <= key_in;
      if (swap_key)       core_key   <= shadow_key;
      if (accept)         core_in_data <= req_data;
      core_in_ready <= accept;
      case ({accept, ret_ok})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      if (key_err | (core_out_ready & inflight_zero) | fifo_overflow) err_sticky <= 1'b1;
    end
  end

  aes_rsp_fifo #(
    .WIDTH(BLOCK_W),
    .DEPTH(FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (core_out_ready),
    .wr_data  (core_out_data),
    .rd_en    (rsp_ready),
    .rd_data  (rsp_data),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (fifo_overflow)
  );

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_aes_enc_scheduler.sv
// tb/tb_aes_enc_scheduler.sv - directed bench for aes_enc_scheduler with a fixed-latency core stand-in
module tb_aes_enc_scheduler;

  localparam int PIPE_LAT   = 106;
  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = 8;
  localparam int TMO        = 500;

  localparam logic [255:0] KEY_A = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_B = 256'hf0e1d2c3b4a5968778695a4b3c2d1e0f00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_A  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [127:0] req_data = '0;
  logic         key_load = 1'b0;
  logic [255:0] key_in = '0;
  logic         key_busy;
  logic [127:0] core_in_data;
  logic         core_in_ready;
  logic [255:0] core_key;
  logic         core_sbox_ready = 1'b0;
  logic [127:0] core_out_data;
  logic         core_out_ready;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [127:0] rsp_data;
  logic [CNT_W-1:0] inflight;
  logic         err_sticky;

  aes_enc_scheduler #(.PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .key_load(key_load), .key_in(key_in), .key_busy(key_busy), .core_in_data(core_in_data),
    .core_in_ready(core_in_ready), .core_key(core_key), .core_sbox_ready(core_sbox_ready),
    .core_out_data(core_out_data), .core_out_ready(core_out_ready), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .inflight(inflight), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stand-in core: known-answer for the FIPS vector, otherwise a key-dependent XOR.
  function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [255:0] k);
    if (k == KEY_A && d == PT_A) return CT_A;
    return d ^ k[255:128] ^ k[127:0];
  endfunction

  logic [PIPE_LAT-1:0] pv = '0;
  logic [127:0]        pd [PIPE_LAT];
  logic                spur = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    pv  <= {pv[PIPE_LAT-2:0], core_in_ready};
    pd[0] <= core_fn(core_in_data, core_key);
    for (int i = PIPE_LAT - 1; i > 0; i--) pd[i] <= pd[i-1];
  end

  assign core_out_ready = pv[PIPE_LAT-1] | spur;
  assign core_out_data  = pd[PIPE_LAT-1];

  logic [127:0] exp_q[$];
  logic [255:0] model_key = '0;
  int acc_seen = 0;
  int rsp_seen = 0;
  int peak = 0;
  int drain_viol = 0;
  int last_acc_cyc = 0;
  int last_acc_inflight = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (int'(inflight) > peak) peak = int'(inflight);
      if (key_busy && req_ready) drain_viol++;
      if (req_valid && req_ready) begin
        exp_q.push_back(core_fn(req_data, model_key));
        acc_seen++;
        last_acc_cyc = cyc;
        last_acc_inflight = int'(inflight);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
        else check("rsp_data", rsp_data, exp_q.pop_front());
        rsp_seen++;
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Must be called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [127:0] d);
    int t = 0;
    req_valid = 1'b1;
    req_data  = d;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      t++;
      if (t > TMO) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    sync();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (exp_q.size() != 0 || inflight != '0) begin
      @(negedge clk);
      t++;
      if (t > 2000) begin
        check("idle_timeout", 0, 1);
        break;
      end
    end
    sync();
  endtask

  initial begin
    int base_acc;
    int base_rsp;
    int t;
    int saw_ready;

    // Reset state and sbox gating
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_core_key", core_key, 0);
    check("rst_inflight", inflight, 0);
    check("rst_flags", {rsp_valid, key_busy, core_in_ready, err_sticky}, 4'b0000);
    sync();
    reset = 1'b1;
    req_valid = 1'b1;
    req_data = PT_A;
    saw_ready = 0;
    repeat (6) begin
      @(negedge clk);
      if (req_ready) saw_ready++;
    end
    check("no_sbox_ready", saw_ready, 0);
    sync();
    req_valid = 1'b0;
    core_sbox_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("no_key_busy", key_busy, 1);
    sync();
    key_load = 1'b1;
    key_in = KEY_A;
    model_key = KEY_A;
    sync();
    key_load = 1'b0;
    @(negedge clk);
    check("key_a_loaded", core_key, KEY_A);
    check("run_not_busy", key_busy, 0);

    // Single known-answer block and latency
    sync();
    send(PT_A);
    t = 0;
    while (!rsp_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("kat_latency", cyc - last_acc_cyc, PIPE_LAT + 2);
    check("kat_data", rsp_data, CT_A);
    wait_idle();

    // 20 back-to-back with consumer always ready
    peak = 0;
    base_rsp = rsp_seen;
    for (int i = 0; i < 20; i++) send({4{32'(i) ^ 32'h5a5a0000}});
    wait_idle();
    check("b2b_count", rsp_seen - base_rsp, 20);
    check("b2b_peak", peak, FIFO_DEPTH);
    check("b2b_err", err_sticky, 0);

    // Consumer stalled: credits cap accepts at FIFO_DEPTH
    rsp_ready = 1'b0;
    base_acc = acc_seen;
    base_rsp = rsp_seen;
    fork
      for (int i = 0; i < 12; i++) send({4{32'hc0de0000 + 32'(i)}});
      begin
        repeat (250) @(negedge clk);
        check("stall_accepts", acc_seen - base_acc, FIFO_DEPTH);
        check("stall_req_ready", req_ready, 0);
        check("stall_rsp_valid", rsp_valid, 1);
        check("stall_inflight", inflight, 0);
        sync();
        rsp_ready = 1'b1;
      end
    join
    wait_idle();
    check("stall_count", rsp_seen - base_rsp, 12);
    check("stall_err", err_sticky, 0);

    // Key change with 3 blocks in flight
    for (int i = 0; i < 3; i++) send({4{32'hab000000 + 32'(i)}});
    key_load = 1'b1;
    key_in = KEY_B;
    model_key = KEY_B;
    req_valid = 1'b1;
    req_data = 128'hfeedface_00000000_11111111_22222222;
    @(negedge clk);
    check("keyload_prio", req_ready, 0);
    check("keyload_inflight", inflight, 3);
    sync();
    key_load = 1'b0;
    @(negedge clk);
    check("drain_busy", key_busy, 1);
    check("drain_old_key", core_key, KEY_A);
    sync();
    drain_viol = 0;
    send(128'hfeedface_00000000_11111111_22222222);
    check("drain_acc_inflight", last_acc_inflight, 0);
    check("drain_no_ready", drain_viol, 0);
    check("key_b_loaded", core_key, KEY_B);
    check("key_done", key_busy, 0);
    wait_idle();
    check("key_err", err_sticky, 0);

    // Spurious core result with nothing in flight
    rsp_ready = 1'b0;
    spur = 1'b1;
    sync();
    spur = 1'b0;
    @(negedge clk);
    check("spur_err", err_sticky, 1);
    check("spur_written", rsp_valid, 1);
    check("spur_inflight", inflight, 0);
    repeat (5) @(negedge clk);
    check("spur_err_sticky", err_sticky, 1);

    // Reset with 5 blocks in flight
    sync();
    for (int i = 0; i < 5; i++) send({4{32'h77000000 + 32'(i)}});
    @(negedge clk);
    check("pre_rst_inflight", inflight, 5);
    #2;
    reset = 1'b0;
    core_sbox_ready = 1'b0;
    #1;
    check("mid_rst_flags", {req_ready, key_busy, core_in_ready, rsp_valid, err_sticky}, 5'b00000);
    check("mid_rst_data", {core_in_data, rsp_data}, 0);
    check("mid_rst_key", core_key, 0);
    check("mid_rst_inflight", inflight, 0);
    exp_q.delete();
    sync();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_wait_sbox", {key_busy, req_ready}, 2'b00);
    sync();
    core_sbox_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_no_key", key_busy, 1);
    t = 0;
    while (!err_sticky && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("late_result_err", err_sticky, 1);
    check("late_result_written", rsp_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
